// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync marker, MSB-first payload, then idle-1 gap bits on x.
// Words enter through a valid/ready handshake, which is accepted only while idle.
module seq_frame_tx #(
    parameter int unsigned             DATA_W   = 8,
    parameter int unsigned             SYNC_W   = 4,
    parameter logic [SYNC_W-1:0]       SYNC     = 4'b0110,
    parameter int unsigned             GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              x,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_CNT = (MAX_SD > GAP_BITS) ? MAX_SD : GAP_BITS;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              x_n;
    logic [SYNC_W-1:0] sync_sh;
    logic              accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shift <= '0;
            x     <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shift <= shift_n;
            x     <= x_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        data_ready = reset && (state == ST_IDLE);
        accept     = data_valid && data_ready;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_GAP) && (cnt == GAP_LAST);

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SYNC;
                    cnt_n   = '0;
                    shift_n = data_in;
                end
            end
            ST_SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                shift_n = shift << 1;
                if (cnt == DATA_LAST) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        // x is registered, so it is derived from the state the line will be in next cycle
        sync_sh = SYNC << cnt_n;
        case (state_n)
            ST_SYNC: x_n = sync_sh[SYNC_W-1];
            ST_DATA: x_n = shift_n[DATA_W-1];
            default: x_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx at default parameters, with a behavioural 0110
// Mealy detector watching x.
module tb_seq_frame_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       x;
    logic       busy;
    logic       frame_done;

    int checks;
    int failures;

    logic [31:0] xs;
    logic [31:0] bs;
    logic [31:0] fds;
    logic [3:0]  hist;
    int          zcount;
    int          zfirst;

    seq_frame_tx #(
        .DATA_W   (8),
        .SYNC_W   (4),
        .SYNC     (4'b0110),
        .GAP_BITS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .x          (x),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples n cycles at negedge; optionally drops valid / changes data after sample i.
    task automatic capture(input int n, input int drop_at, input int chg_at,
                           input logic [7:0] chg_val);
        xs     = '0;
        bs     = '0;
        fds    = '0;
        hist   = 4'b1111;
        zcount = 0;
        zfirst = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            xs   = {xs[30:0], x};
            bs   = {bs[30:0], busy};
            fds  = {fds[30:0], frame_done};
            hist = {hist[2:0], x};
            if (hist == 4'b0110) begin
                zcount++;
                if (zcount == 1) zfirst = i;
            end
            if (i == drop_at) data_valid = 1'b0;
            if (i == chg_at)  data_in = chg_val;
        end
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (data_ready !== 1'b0 || x !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got ready=%b x=%b busy=%b fd=%b exp ready=0 x=1 busy=0 fd=0",
                         i, data_ready, x, busy, frame_done);
            end
        end
        reset      = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b1 || x !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b x=%b busy=%b exp ready=1 x=1 busy=0",
                     data_ready, x, busy);
        end
    endtask

    task automatic test_single;
        checks++;
        if (data_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b exp=1", data_ready);
        end
        data_in    = 8'hA5;
        data_valid = 1'b1;
        capture(14, 0, -1, 8'h00);
        checks++;
        if (xs[13:0] !== 14'b0110_10100101_11) begin
            failures++;
            $display("FAIL single_bits got=%b exp=%b", xs[13:0], 14'b0110_10100101_11);
        end
        checks++;
        if (bs[13:0] !== 14'h3FFF) begin
            failures++;
            $display("FAIL single_busy got=%b exp=%b", bs[13:0], 14'h3FFF);
        end
        checks++;
        if (fds[13:0] !== 14'b00000000000001) begin
            failures++;
            $display("FAIL single_done got=%b exp=%b", fds[13:0], 14'b00000000000001);
        end
        checks++;
        if (zcount !== 1 || zfirst !== 3) begin
            failures++;
            $display("FAIL single_detect got count=%0d pos=%0d exp count=1 pos=3", zcount, zfirst);
        end
        capture(3, -1, -1, 8'h00);
        checks++;
        if (xs[2:0] !== 3'b111 || bs[2:0] !== 3'b000 || fds[2:0] !== 3'b000 || data_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_idle got x=%b busy=%b fd=%b ready=%b exp x=111 busy=000 fd=000 ready=1",
                     xs[2:0], bs[2:0], fds[2:0], data_ready);
        end
    endtask

    task automatic test_back_to_back;
        data_in    = 8'h0F;
        data_valid = 1'b1;
        capture(29, 15, 0, 8'hF0);
        checks++;
        if (xs[28:0] !== 29'b0110_00001111_11_1_0110_11110000_11) begin
            failures++;
            $display("FAIL b2b_bits got=%b exp=%b", xs[28:0], 29'b0110_00001111_11_1_0110_11110000_11);
        end
        checks++;
        if (fds[28:0] !== 29'b00000000000001_0_00000000000001) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=%b", fds[28:0], 29'b00000000000001_0_00000000000001);
        end
        checks++;
        if (bs[28:0] !== 29'b11111111111111_0_11111111111111) begin
            failures++;
            $display("FAIL b2b_busy got=%b exp=%b", bs[28:0], 29'b11111111111111_0_11111111111111);
        end
        checks++;
        if (zcount !== 2) begin
            failures++;
            $display("FAIL b2b_detect got=%0d exp=2", zcount);
        end
        capture(2, -1, -1, 8'h00);
    endtask

    task automatic test_payload_sync;
        data_in    = 8'h66;
        data_valid = 1'b1;
        capture(14, 0, -1, 8'h00);
        checks++;
        if (xs[13:0] !== 14'b0110_01100110_11) begin
            failures++;
            $display("FAIL p66_bits got=%b exp=%b", xs[13:0], 14'b0110_01100110_11);
        end
        checks++;
        if (zcount !== 3) begin
            failures++;
            $display("FAIL p66_detect got=%0d exp=3", zcount);
        end
        capture(2, -1, -1, 8'h00);
    endtask

    task automatic test_reset_mid_frame;
        data_in    = 8'hC5;
        data_valid = 1'b1;
        capture(7, 0, -1, 8'h00);
        checks++;
        if (xs[6:0] !== 7'b0110_110) begin
            failures++;
            $display("FAIL abort_prefix got=%b exp=%b", xs[6:0], 7'b0110110);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (x !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || data_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset got x=%b busy=%b fd=%b ready=%b exp x=1 busy=0 fd=0 ready=0",
                     x, busy, frame_done, data_ready);
        end
        reset = 1'b1;
        capture(14, -1, -1, 8'h00);
        checks++;
        if (xs[13:0] !== 14'h3FFF || fds[13:0] !== 14'h0000 || bs[13:0] !== 14'h0000) begin
            failures++;
            $display("FAIL abort_quiet got x=%b fd=%b busy=%b exp x=all1 fd=0 busy=0",
                     xs[13:0], fds[13:0], bs[13:0]);
        end
        data_in    = 8'h81;
        data_valid = 1'b1;
        capture(14, 0, -1, 8'h00);
        checks++;
        if (xs[13:0] !== 14'b0110_10000001_11 || fds[13:0] !== 14'b00000000000001) begin
            failures++;
            $display("FAIL abort_next got x=%b fd=%b exp x=%b fd=%b", xs[13:0], fds[13:0],
                     14'b0110_10000001_11, 14'b00000000000001);
        end
        capture(2, -1, -1, 8'h00);
    endtask

    task automatic test_data_change;
        data_in    = 8'hC3;
        data_valid = 1'b1;
        capture(14, 0, 0, 8'h00);
        checks++;
        if (xs[13:0] !== 14'b0110_11000011_11) begin
            failures++;
            $display("FAIL hold_bits got=%b exp=%b", xs[13:0], 14'b0110_11000011_11);
        end
        capture(2, -1, -1, 8'h00);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_payload_sync;
        test_reset_mid_frame;
        test_data_change;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter. Produces the bit stream that the team's "0110" Mealy sequence detector consumes.
- Accepts parallel data words through a valid/ready handshake. Emits each word as one frame on a single serial line `x`: sync marker 0110, then payload MSB-first, then idle gap bits.
- The line idles at 1. A downstream 0110 detector therefore stays in its start state between frames and fires exactly on the last sync bit.

Parameters:
- DATA_W, 8, payload bits per frame (1..32).
- SYNC, 4'b0110, sync marker, sent MSB-first.
- SYNC_W, 4, sync marker width.
- GAP_BITS, 2, idle-1 bits after the payload (1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- data_in  in  DATA_W  payload word; sampled only at the handshake.
- data_valid  in  1  upstream has a word.
- data_ready  out  1  block can accept a word.
- x  out  1  serial output bit, registered.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on the last gap bit of a frame.

Behaviour:
- One clock. All state updates on posedge clk. Reset is sampled on posedge clk only.
- Reset values (reset==0): state=IDLE, x=1, busy=0, frame_done=0, shift register=0, bit counter=0. data_ready is forced 0 while reset==0.
- States:
  - IDLE: x=1, data_ready=1.
  - SYNC: SYNC_W cycles.
  - DATA: DATA_W cycles.
  - GAP: GAP_BITS cycles, x=1.
- Handshake: a transfer occurs on the clock edge where data_valid && data_ready. data_in is latched into the shift register. Next state is SYNC with counter=0.
- data_valid while data_ready==0 has no effect. The upstream must hold the word. No acceptance or buffering occurs while busy.
- Latency: the first sync bit (SYNC[SYNC_W-1]=0) appears on x in the cycle immediately after the handshake edge.
- SYNC: x = SYNC[SYNC_W-1-cnt]. After cnt==SYNC_W-1, go to DATA with cnt=0.
- DATA: x = shift[DATA_W-1]. Shift left by one each cycle. After cnt==DATA_W-1, go to GAP with cnt=0.
- GAP: x=1. frame_done=1 in the cycle where cnt==GAP_BITS-1. The next state is IDLE.
- Frame length: SYNC_W+DATA_W+GAP_BITS cycles, 14 at the defaults.
- busy=1 in SYNC, DATA and GAP. busy=0 in IDLE.
- Back-to-back frames: data_ready rises in the IDLE cycle after the last gap bit. A word already presented is accepted at that edge. Minimum spacing is therefore GAP_BITS+1 idle-1 bits between frames.
- Counter width: clog2 of max(SYNC_W, DATA_W, GAP_BITS). The counter never wraps within a state. It is cleared on every state change.
- Reset mid-frame: the frame is aborted. On the next cycle x=1 and state=IDLE. frame_done does not pulse. The partial word is discarded.
- Changes to data_in after the handshake do not affect the frame in flight.
- Payload containing 0110 is sent unmodified; no bit stuffing is performed. Framing is sync-relative at the receiver.

Test Plan:
- Reset is held 0 for 3 cycles while data_valid=1 → no transfer, data_ready=0, x=1. After release, data_ready=1 in the first cycle.
- Single frame, data_in=8'hA5, one-cycle valid → x from the next cycle is 0,1,1,0,1,0,1,0,0,1,0,1,1,1, then 1 steady.
  - busy is high for exactly 14 cycles.
  - frame_done pulses on cycle 14 only.
  - A connected 0110 detector pulses z exactly once, on the 4th bit.
- Back-to-back: data_valid held 1 with words 8'h0F then 8'hF0 → second accepted on the edge after frame_done.
  - Streams are 0110 00001111 11 | 1 | 0110 11110000 11.
  - Exactly 2 frame_done pulses.
- Payload 8'h66 → x = 0110 01100110 11. Bits are exact and the transmitter does not alter the payload.
- Reset asserted in the 3rd DATA cycle → x=1 from the next cycle. No frame_done. Next word 8'h81 frames correctly.
- data_in changed to 8'h00 mid-frame after 8'hC3 was accepted → payload bits remain 11000011.
